// File: rtl/hub_scan_pkg.sv
// Shared types and helpers for the HUB BCM row-scan controller.
package hub_scan_pkg;

  localparam int unsigned CH_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StGamma,
    StShiftLo,
    StShiftHi,
    StLatch,
    StDisplay,
    StNext
  } scan_state_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb888_t;

  // floor(255 * (v/255)^2.2); only evaluated with constant arguments to fill the ROM.
  function automatic logic [CH_W-1:0] gamma22(input logic [CH_W-1:0] v);
    real norm;
    norm = real'(v) / 255.0;
    return CH_W'($rtoi((norm ** 2.2) * 255.0));
  endfunction

endpackage

// File: rtl/hub_gamma_lut.sv
// Registered 256x8 gamma-2.2 ROM; one instance per colour channel per panel.
module hub_gamma_lut
  import hub_scan_pkg::*;
(
  input  logic            clk_i,
  input  logic [CH_W-1:0] addr,
  output logic [CH_W-1:0] data
);

  logic [CH_W-1:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    assign rom[i] = gamma22(CH_W'(i));
  end

  always_ff @(posedge clk_i) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/hub_bcm_scan.sv
// HUB LED matrix row-scan controller with binary-code modulation.
// Define HUB_SCAN_GAMMA_EN to route every channel through a registered gamma ROM.
module hub_bcm_scan
  import hub_scan_pkg::*;
#(
  parameter int unsigned PANEL_NUM = 4,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 16,
  parameter int unsigned PWM_DEPTH = 8,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned BASE_CYC  = 4,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   en_i,
  output logic                                   pix_rd_o,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   pix_addr_o,
  input  logic [PANEL_NUM*24-1:0]                pix_data_i,
  output logic [$clog2(ROWS)-1:0]                row_sel_o,
  output logic                                   sclk_o,
  output logic                                   latch_o,
  output logic                                   oe_n_o,
  output logic [PANEL_NUM-1:0]                   r_o,
  output logic [PANEL_NUM-1:0]                   g_o,
  output logic [PANEL_NUM-1:0]                   b_o,
  output logic                                   frame_end_o,
  output logic                                   busy_o
);

  localparam int unsigned ROW_W    = $clog2(ROWS);
  localparam int unsigned COL_W    = $clog2(COLS);
  localparam int unsigned PL_W     = (PWM_DEPTH > 1) ? $clog2(PWM_DEPTH) : 1;
  localparam int unsigned DISP_MAX = BASE_CYC << (PWM_DEPTH - 1);
  localparam int unsigned DISP_W   = $clog2(DISP_MAX) + 1;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV) + 1;
  localparam int unsigned BLK_W    = $clog2(BLANK_CYC) + 1;
  localparam int unsigned CNT_W    = (DISP_W > DIV_W) ? ((DISP_W > BLK_W) ? DISP_W : BLK_W)
                                                      : ((DIV_W > BLK_W) ? DIV_W : BLK_W);
`ifdef HUB_SCAN_GAMMA_EN
  localparam bit GAMMA_EN = 1'b1;
`else
  localparam bit GAMMA_EN = 1'b0;
`endif

  scan_state_e state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [PL_W-1:0]  plane_q, plane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_end_q, frame_end_d;
  logic             pix_rd_q, sclk_q, latch_q, oe_n_q, busy_q;
  logic [PANEL_NUM-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  rgb888_t         pix   [PANEL_NUM];
  logic [CH_W-1:0] src_r [PANEL_NUM];
  logic [CH_W-1:0] src_g [PANEL_NUM];
  logic [CH_W-1:0] src_b [PANEL_NUM];

  for (genvar p = 0; p < PANEL_NUM; p++) begin : g_panel
    assign pix[p] = rgb888_t'(pix_data_i[24*p +: 24]);
`ifdef HUB_SCAN_GAMMA_EN
    hub_gamma_lut u_gamma_r (.clk_i(clk_i), .addr(pix[p].r), .data(src_r[p]));
    hub_gamma_lut u_gamma_g (.clk_i(clk_i), .addr(pix[p].g), .data(src_g[p]));
    hub_gamma_lut u_gamma_b (.clk_i(clk_i), .addr(pix[p].b), .data(src_b[p]));
`else
    assign src_r[p] = pix[p].r;
    assign src_g[p] = pix[p].g;
    assign src_b[p] = pix[p].b;
`endif
  end

  // Planes are LSB first, taken from the top PWM_DEPTH bits of each channel.
  logic [2:0] bit_idx;
  logic       load_rgb;
  assign bit_idx  = 3'(CH_W - PWM_DEPTH) + 3'(plane_q);
  assign load_rgb = (state_q == StShiftLo) && (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (load_rgb) begin
      for (int p = 0; p < int'(PANEL_NUM); p++) begin
        r_d[p] = src_r[p][bit_idx];
        g_d[p] = src_g[p][bit_idx];
        b_d[p] = src_b[p][bit_idx];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    plane_d     = plane_q;
    cnt_d       = cnt_q;
    frame_end_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (en_i) state_d = StFetch;
      end
      StFetch: begin
        state_d = GAMMA_EN ? StGamma : StShiftLo;
        cnt_d   = CNT_W'(CLK_DIV - 1);
      end
      StGamma: begin
        state_d = StShiftLo;
        cnt_d   = CNT_W'(CLK_DIV - 1);
      end
      StShiftLo: begin
        if (cnt_q == '0) begin
          state_d = StShiftHi;
          cnt_d   = CNT_W'(CLK_DIV - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StShiftHi: begin
        if (cnt_q == '0) begin
          if (col_q == COL_W'(COLS - 1)) begin
            state_d = StLatch;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = StFetch;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StLatch: begin
        col_d   = '0;
        state_d = StDisplay;
        cnt_d   = (CNT_W'(BASE_CYC) << plane_q) - CNT_W'(1);
      end
      StDisplay: begin
        if (cnt_q == '0) begin
          if (plane_q != PL_W'(PWM_DEPTH - 1)) begin
            plane_d = plane_q + PL_W'(1);
            state_d = StFetch;
          end else begin
            plane_d     = '0;
            state_d     = StNext;
            cnt_d       = CNT_W'(BLANK_CYC - 1);
            row_d       = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
            frame_end_d = (row_q == ROW_W'(ROWS - 1));
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StNext: begin
        // en_i is only honoured here so a row always completes all its planes.
        if (cnt_q == '0) begin
          state_d = en_i ? StFetch : StIdle;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      plane_q     <= '0;
      cnt_q       <= '0;
      frame_end_q <= 1'b0;
      pix_rd_q    <= 1'b0;
      sclk_q      <= 1'b0;
      latch_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      plane_q     <= plane_d;
      cnt_q       <= cnt_d;
      frame_end_q <= frame_end_d;
      // Pin strobes are registered from the next state to keep them glitch-free.
      pix_rd_q    <= (state_d == StFetch);
      sclk_q      <= (state_d == StShiftHi);
      latch_q     <= (state_d == StLatch);
      oe_n_q      <= (state_d != StDisplay);
      busy_q      <= (state_d != StIdle);
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign pix_rd_o    = pix_rd_q;
  assign pix_addr_o  = {row_q, col_q};
  assign row_sel_o   = row_q;
  assign sclk_o      = sclk_q;
  assign latch_o     = latch_q;
  assign oe_n_o      = oe_n_q;
  assign r_o         = r_q;
  assign g_o         = g_q;
  assign b_o         = b_q;
  assign frame_end_o = frame_end_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_hub_bcm_scan.sv
// Self-checking bench for hub_bcm_scan: per-cycle trace model plus literal frame-timing pins.
module tb_hub_bcm_scan;

  localparam int PN = 2;
  localparam int RW = 4;
  localparam int CL = 4;
  localparam int PD = 2;
  localparam int CD = 1;
  localparam int BC = 4;
  localparam int BL = 2;
  localparam int AW = 4;
`ifdef HUB_SCAN_GAMMA_EN
  localparam int GX        = 1;
  localparam int ROW_CYC   = 48;
  localparam int FRAME_CYC = 192;
  localparam int FE_OFS    = 190;
  localparam int PLANE0    = 21;
  localparam int COL_PER   = 4;
`else
  localparam int GX        = 0;
  localparam int ROW_CYC   = 40;
  localparam int FRAME_CYC = 160;
  localparam int FE_OFS    = 158;
  localparam int PLANE0    = 17;
  localparam int COL_PER   = 3;
`endif
  localparam int SLOT = 1 + GX + 2 * CD;

  logic clk = 1'b0;
  logic rst_i, en_i;
  logic pix_rd, sclk, latch, oe_n, fe, busy;
  logic [AW-1:0] pix_addr;
  logic [PN*24-1:0] pix_data = '0;
  logic [1:0] row_sel;
  logic [PN-1:0] r, g, b;

  always #5 clk = ~clk;

  hub_bcm_scan #(
    .PANEL_NUM(PN), .ROWS(RW), .COLS(CL), .PWM_DEPTH(PD),
    .CLK_DIV(CD), .BASE_CYC(BC), .BLANK_CYC(BL)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i),
    .pix_rd_o(pix_rd), .pix_addr_o(pix_addr), .pix_data_i(pix_data),
    .row_sel_o(row_sel), .sclk_o(sclk), .latch_o(latch), .oe_n_o(oe_n),
    .r_o(r), .g_o(g), .b_o(b), .frame_end_o(fe), .busy_o(busy)
  );

  // Frame buffer with one-cycle read latency.
  logic [PN*24-1:0] mem [16];
  always @(posedge clk) if (pix_rd) pix_data <= mem[pix_addr];

  typedef struct packed {
    logic rd; logic [AW-1:0] addr; logic [1:0] row;
    logic sclk; logic latch; logic oe_n;
    logic [PN-1:0] r; logic [PN-1:0] g; logic [PN-1:0] b;
    logic fe; logic busy;
  } obs_t;

  obs_t exp_q [$];
  int n_cmp = 0, n_bad = 0;
  int m_row = 0;
  logic [PN-1:0] m_r = '0, m_g = '0, m_b = '0;
  obs_t rst_obs;

  function automatic obs_t sample();
    obs_t o;
    o.rd = pix_rd; o.addr = pix_addr; o.row = row_sel; o.sclk = sclk; o.latch = latch;
    o.oe_n = oe_n; o.r = r; o.g = g; o.b = b; o.fe = fe; o.busy = busy;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("rd=%b addr=%h row=%0d sclk=%b latch=%b oe_n=%b r=%b g=%b b=%b fe=%b busy=%b",
                     o.rd, o.addr, o.row, o.sclk, o.latch, o.oe_n, o.r, o.g, o.b, o.fe, o.busy);
  endfunction

`ifdef HUB_SCAN_GAMMA_EN
  function automatic logic [7:0] gam(input logic [7:0] v);
    real x;
    x = real'(v) / 255.0;
    return 8'($rtoi((x ** 2.2) * 255.0));
  endfunction
`endif

  // Bit of plane pl for panel p, colour k (0=R,1=G,2=B) at address a.
  function automatic logic chan_bit(int a, int p, int k, int pl);
    logic [7:0] v;
    v = mem[a][24*p + 8*(2-k) +: 8];
`ifdef HUB_SCAN_GAMMA_EN
    v = gam(v);
`endif
    return v[8 - PD + pl];
  endfunction

  function automatic obs_t base_obs(logic bz);
    obs_t o;
    o = '0;
    o.row = 2'(m_row); o.oe_n = 1'b1; o.busy = bz;
    o.r = m_r; o.g = m_g; o.b = m_b;
    return o;
  endfunction

  function automatic void push_idle(int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base_obs(1'b0));
  endfunction

  // Expected pin trace of one whole row, then blanking, then idle if scanning stops.
  function automatic void push_row(bit stay_on);
    obs_t o;
    logic [PN-1:0] nr, ng, nb;
    for (int pl = 0; pl < PD; pl++) begin
      for (int c = 0; c < CL; c++) begin
        for (int p = 0; p < PN; p++) begin
          nr[p] = chan_bit(m_row * CL + c, p, 0, pl);
          ng[p] = chan_bit(m_row * CL + c, p, 1, pl);
          nb[p] = chan_bit(m_row * CL + c, p, 2, pl);
        end
        for (int k = 0; k < SLOT; k++) begin
          if (k == 2 + GX) begin m_r = nr; m_g = ng; m_b = nb; end
          o = base_obs(1'b1);
          o.rd   = (k == 0);
          o.addr = (k == 0) ? AW'(m_row * CL + c) : '0;
          o.sclk = (k >= SLOT - CD);
          exp_q.push_back(o);
        end
      end
      o = base_obs(1'b1); o.latch = 1'b1; exp_q.push_back(o);
      for (int i = 0; i < (BC << pl); i++) begin
        o = base_obs(1'b1); o.oe_n = 1'b0; exp_q.push_back(o);
      end
    end
    m_row = (m_row + 1) % RW;
    for (int k = 0; k < BL; k++) begin
      o = base_obs(1'b1); o.fe = (k == 0) && (m_row == 0); exp_q.push_back(o);
    end
    if (!stay_on) push_idle(3);
  endfunction

  // Cycle-by-cycle comparison against the model trace.
  obs_t cmp_e, cmp_a;
  always @(negedge clk) begin
    if (rst_i && exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      cmp_a = sample();
      if (!cmp_e.rd) cmp_a.addr = '0;
      n_cmp++;
      if (cmp_a !== cmp_e) begin
        n_bad++;
        $display("FAIL trace @%0t: got %s | want %s", $time, fmt(cmp_a), fmt(cmp_e));
      end
    end
  end

  // Timing monitor for the literal frame/column checks.
  int cyc = 0, fe_cnt = 0, fe_cyc = 0, sclk_rise = 0, sclk_gap = 0, last_rise = 0, oe_low = 0;
  int a0_t [$];
  logic sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_i) begin
      cyc++;
      if (pix_rd && pix_addr == '0) a0_t.push_back(cyc);
      if (fe) begin fe_cnt++; fe_cyc = cyc; end
      if (sclk && !sclk_prev) begin sclk_rise++; sclk_gap = cyc - last_rise; last_rise = cyc; end
      if (!oe_n) oe_low++;
      sclk_prev = sclk;
    end
  end

  task automatic clr_mon();
    fe_cnt = 0; sclk_rise = 0; oe_low = 0; a0_t.delete();
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_obs(input string name, input obs_t want);
    obs_t a;
    a = sample();
    n_cmp++;
    if (a !== want) begin
      n_bad++;
      $display("FAIL %s: got %s | want %s", name, fmt(a), fmt(want));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("trace_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_obs = '0;
    rst_obs.oe_n = 1'b1;
    rst_i = 1'b0;
    en_i  = 1'b0;
    for (int a = 0; a < 16; a++) mem[a] = {8'hC0, 8'h80, 8'h00, 8'hC0, 8'h40, 8'h00};
    tick(3);
    check_obs("reset_state", rst_obs);
    rst_i = 1'b1;
    tick(2);
    check_obs("idle_after_reset", rst_obs);

    // Six rows: a full frame plus rows 0..1, en_i dropped mid-row 1.
    clr_mon();
    en_i = 1'b1;
    push_idle(1);
    for (int i = 0; i < 5; i++) push_row(1'b1);
    push_row(1'b0);
    tick(5 * ROW_CYC + 21);
    en_i = 1'b0;
    drain(800);
    check("frame_end_count", fe_cnt, 1);
    check("addr0_fetches", a0_t.size(), 4);
    if (a0_t.size() >= 4) begin
      check("plane0_length", a0_t[1] - a0_t[0], PLANE0);
      check("frame_length", a0_t[2] - a0_t[0], FRAME_CYC);
      check("frame_end_offset", fe_cyc - a0_t[0], FE_OFS);
    end
    check("sclk_pulses", sclk_rise, 48);
    check("column_period", sclk_gap, COL_PER);
    check("oe_low_cycles", oe_low, 72);
    check("row_after_stop", int'(row_sel), 2);
    check("busy_after_stop", int'(busy), 0);
    check("oe_n_after_stop", int'(oe_n), 1);

    // Varied pixels, rows 2 and 3 with the wrap to row 0.
    for (int a = 0; a < 16; a++)
      for (int p = 0; p < PN; p++)
        mem[a][24*p +: 24] = {8'(a * 16 + p * 64), 8'(255 - a * 16 - p * 64), 8'(a * 53 + p * 128)};
    clr_mon();
    en_i = 1'b1;
    push_idle(1);
    push_row(1'b1);
    push_row(1'b0);
    tick(ROW_CYC + 21);
    en_i = 1'b0;
    drain(400);
    check("frame_end_wrap", fe_cnt, 1);
    check("row_after_wrap", int'(row_sel), 0);

    // Asynchronous reset in the middle of DISPLAY.
    en_i = 1'b1;
    push_idle(1);
    push_row(1'b1);
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (!oe_n) break;
    end
    check("display_reached", int'(oe_n), 0);
    #2 rst_i = 1'b0;
    exp_q.delete();
    #1 check_obs("async_reset", rst_obs);
    en_i = 1'b0;
    m_row = 0; m_r = '0; m_g = '0; m_b = '0;
    tick(2);
    rst_i = 1'b1;
    tick(2);
    check_obs("idle_after_async_reset", rst_obs);

    // Restart from row 0 after the reset.
    en_i = 1'b1;
    push_idle(1);
    push_row(1'b0);
    tick(21);
    en_i = 1'b0;
    drain(200);
    check("row_after_restart", int'(row_sel), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hub_bcm_scan.md
Name: hub_bcm_scan

Overview:
- Next-generation LED matrix row-scan controller. Drives PANEL_NUM HUB-style panels in parallel: a shared row select and shared shift clock, latch and output-enable, plus per-panel R/G/B serial data.
- Produces grey scale by binary-code modulation (BCM) across PWM_DEPTH bit-planes, replacing compare-based PWM.
- Reads pixels from the frame buffer through a 1-cycle-latency read port instead of a full-frame array input.
- Sits between the frame buffer and the panel pins; `frame_end_o` feeds the buffer-swap logic.

Parameters:
- PANEL_NUM, 4, number of panels driven in parallel.
- ROWS, 8, scanned rows per panel.
- COLS, 16, columns shifted per row per panel.
- PWM_DEPTH, 8, BCM bit-planes (1..8); uses channel bits [7 -: PWM_DEPTH].
- CLK_DIV, 2, clk_i cycles per shift-clock half period (>=1).
- BASE_CYC, 4, display cycles for the LSB plane (>=1).
- BLANK_CYC, 2, oe_n-high cycles after a row change (>=1).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-low.
- en_i  in  1  scan enable.
- pix_rd_o  out  1  pixel read strobe.
- pix_addr_o  out  clog2(ROWS)+clog2(COLS)  {row, col}.
- pix_data_i  in  PANEL_NUM*24  panel p at [24p+23:24p], {R,G,B} 8 bits each; valid the cycle after pix_rd_o.
- row_sel_o  out  clog2(ROWS)  row address.
- sclk_o  out  1  column shift clock.
- latch_o  out  1  latch pulse.
- oe_n_o  out  1  output enable, active-low.
- r_o / g_o / b_o  out  PANEL_NUM each  serial colour data, bit p = panel p.
- frame_end_o  out  1  one-cycle pulse at frame end.
- busy_o  out  1  high outside IDLE.

Behaviour:
- Reset (async, immediate, also mid-operation): state IDLE, row 0, plane 0, col 0; sclk 0, latch 0, oe_n 1, row_sel 0, rgb 0, pix_rd 0, pix_addr 0, frame_end 0, busy 0.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY, NEXT.
- IDLE: oe_n=1. Moves to FETCH when en_i=1 and sampled.
- FETCH (1 cycle): pix_rd=1, pix_addr={row,col}.
- SHIFT_LO (CLK_DIV cycles): sclk=0. On its first cycle, registers r_o[p] = R_p[8-PWM_DEPTH+plane]; G and B likewise.
- SHIFT_HI (CLK_DIV cycles): sclk=1. Afterwards, col++ and return to FETCH, or go to LATCH when col==COLS-1.
- Column slot = 1+2*CLK_DIV cycles. Column 0 is shifted first.
- LATCH (1 cycle): latch=1, sclk=0, col cleared.
- DISPLAY: oe_n=0 for exactly BASE_CYC<<plane cycles. Counter width clog2(BASE_CYC<<(PWM_DEPTH-1))+1.
- After DISPLAY:
  - plane < PWM_DEPTH-1: plane++, go to FETCH.
  - otherwise: go to NEXT.
- Planes are ordered LSB first. oe_n is high in every state except DISPLAY.
- NEXT (BLANK_CYC cycles, oe_n=1): row_sel updates on the first cycle, plane cleared.
  - Row wraps ROWS-1 -> 0.
  - On wrap, frame_end_o pulses on the first NEXT cycle.
- en_i sampled low in NEXT returns the block to IDLE after blanking. en_i is ignored in all other states, so a row is never truncated.
- Duty: channel value v gives on-time BASE_CYC*(v>>(8-PWM_DEPTH)) per row. v=0 is never lit. With PWM_DEPTH=8, v=255 is lit in all planes.
- rgb holds its last shifted value through LATCH and DISPLAY.

Optional Feature:
- Macro: HUB_SCAN_GAMMA_EN.
- Defined: each 8-bit channel passes through a 256-entry gamma ROM (gamma 2.2, g(0)=0, g(255)=255) before plane extraction. The ROM is registered, so each column slot gains one cycle (2+2*CLK_DIV).
- Undefined: raw channel bits are used; slot is 1+2*CLK_DIV.

Decomposition:
- Package hub_scan_pkg holds:
  - state enum typedef;
  - the rgb888 struct;
  - function gamma22(8-bit) -> 8-bit, used to build the ROM;
  - channel-width constant 8.
- One sub-module, hub_gamma_lut: a registered 256x8 ROM, instantiated 3*PANEL_NUM times under the macro.

Test Plan (PANEL_NUM=2, ROWS=4, COLS=4, PWM_DEPTH=2, CLK_DIV=1, BASE_CYC=4, BLANK_CYC=2, macro off unless stated):
- Reset, then en_i=1 -> first pix_rd at addr 0 one cycle after en_i is sampled; 4 sclk pulses, each 1 cycle high, 3-cycle column period; latch pulses 1 cycle after the 4th sclk fall.
- All pixels R=0xC0 (MSB plane only) -> r_o=0 in plane 0, oe_n low 4 cycles; r_o=1 in plane 1, oe_n low 8 cycles; row_sel increments with oe_n high for 2 cycles.
- Panel0 G=0x40, panel1 G=0x80 -> g_o=2'b01 during plane 0 shifting and 2'b10 during plane 1 shifting; B=0 keeps b_o=0 throughout.
- Run a full frame -> exactly one frame_end_o pulse, coinciding with row_sel 3->0; total frame = 4 rows x (2x(12+1)+4+8+2) = 160 cycles.
- en_i dropped mid-row 1 -> planes of row 1 complete, row_sel becomes 2, then IDLE with busy_o=0 and oe_n=1; rst_i pulsed low during DISPLAY -> oe_n goes 1 asynchronously, all outputs at reset values.
- HUB_SCAN_GAMMA_EN defined, R=0x80 -> gamma value 0x37 drives r_o (plane 0 = bit 6 = 0, plane 1 = bit 7 = 0); column period becomes 4 cycles.
